// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Signal bundle between the UART receiver and the APB register
//               side. The "slave" modport is the receiver's view. The
//               "master" modport is the view of whatever drives tick/Rxd/Rx_rd.
//   tick      : 1-PCLK enable pulse, OVERSAMPLE per bit period
//   Rxd       : asynchronous serial input, idle high
//   Rx_rd     : 1-cycle read strobe, consumes the holding register
//   rx_data   : last accepted byte
//   rx_valid  : holding register full
//   RxD_done  : 1-cycle pulse when a frame completes
//   frame_err : stop bit of the byte in rx_data was 0
//   overrun   : sticky, a frame was dropped while the holding register was full
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 Rxd;
    logic                 Rx_rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 RxD_done;
    logic                 frame_err;
    logic                 overrun;

    modport slave (
        input  tick,
        input  Rxd,
        input  Rx_rd,
        output rx_data,
        output rx_valid,
        output RxD_done,
        output frame_err,
        output overrun
    );

    modport master (
        output tick,
        output Rxd,
        output Rx_rd,
        input  rx_data,
        input  rx_valid,
        input  RxD_done,
        input  frame_err,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 16x oversampling enable (tick). LSB-first
//               deserialisation into a one-entry holding register, with
//               framing-error and sticky overrun reporting.
// Ports       : PCLK    - clock, all logic on the rising edge
//               PRESETn - synchronous active-low reset
//               bus     - uart_rx_if.slave (tick, Rxd, Rx_rd in;
//                         rx_data, rx_valid, RxD_done, frame_err, overrun out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic     PCLK,
    input  logic     PRESETn,
    uart_rx_if.slave bus
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
    logic [DATA_BITS-1:0] sh, sh_nxt;
    logic                 stop_sample;

    logic                 rxd_meta;
    logic                 rxd_s;

    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 done_reg;
    logic                 ferr_reg;
    logic                 ovr_reg;
    logic                 do_load;

    // Two-flop synchroniser; resets to the idle (high) line level so that a
    // reset never looks like a start bit.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= bus.Rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Receive FSM state and datapath registers
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= S_IDLE;
            cnt   <= '0;
            bcnt  <= '0;
            sh    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bcnt  <= bcnt_nxt;
            sh    <= sh_nxt;
        end
    end

    // Everything advances only on tick cycles; without tick the FSM freezes.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bcnt_nxt    = bcnt;
        sh_nxt      = sh;
        stop_sample = 1'b0;
        if (bus.tick) begin
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        cnt_nxt   = '0;
                        state_nxt = S_START;
                    end
                end
                S_START: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_MID) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rxd_s) begin
                            cnt_nxt   = '0;
                            bcnt_nxt  = '0;
                            state_nxt = S_DATA;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_END) begin
                        sh_nxt   = {rxd_s, sh[DATA_BITS-1:1]};
                        cnt_nxt  = '0;
                        bcnt_nxt = bcnt + 1'b1;
                        if (bcnt == BCNT_LAST) begin
                            state_nxt = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_END) begin
                        stop_sample = 1'b1;
                        cnt_nxt     = '0;
                        // A low stop bit may be a break; wait for the line to
                        // return high before hunting for the next start bit.
                        state_nxt   = rxd_s ? S_IDLE : S_BRK;
                    end
                end
                S_BRK: begin
                    if (rxd_s) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // A read in the same cycle as the stop sample frees the holding register
    // just in time, so the new frame is accepted instead of overrunning.
    assign do_load = stop_sample && (!valid_reg || bus.Rx_rd);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            done_reg <= stop_sample;
            if (do_load) begin
                data_reg  <= sh;
                ferr_reg  <= ~rxd_s;
                valid_reg <= 1'b1;
                if (bus.Rx_rd) begin
                    ovr_reg <= 1'b0;
                end
            end else begin
                // Dropping a frame implies Rx_rd is low, so these never collide.
                if (stop_sample) begin
                    ovr_reg <= 1'b1;
                end
                if (bus.Rx_rd) begin
                    valid_reg <= 1'b0;
                    ovr_reg   <= 1'b0;
                end
            end
        end
    end

    assign bus.rx_data   = data_reg;
    assign bus.rx_valid  = valid_reg;
    assign bus.RxD_done  = done_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.overrun   = ovr_reg;

endmodule
`default_nettype wire
